rf_wb_arbiter: RTL and testbench

//  Write-side requester for the triple-ported register file: merges results from two producers (ALU, MEM)

---
 rtl/rf_wb_pkg.sv | 23 ++
 rtl/wb_hold_reg.sv | 60 ++++++
 rtl/rf_wb_arbiter.sv | 168 ++++++++++++++++
 tb/tb_rf_wb_arbiter.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_wb_pkg.sv
// -----------------------------------------------------------------------------
// rf_wb_pkg
// Shared definitions for the register-file write-back arbiter slice.
//   WB_DATA_W / WB_ADDR_W : default data and register-address widths
//   wb_req_t              : one write request (destination register + data)
//   src_e                 : identifies a write-back producer
// -----------------------------------------------------------------------------
package rf_wb_pkg;

    localparam int unsigned WB_DATA_W = 16;
    localparam int unsigned WB_ADDR_W = 4;

    typedef struct packed {
        logic [WB_ADDR_W-1:0] addr;
        logic [WB_DATA_W-1:0] data;
    } wb_req_t;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_MEM = 1'b1
    } src_e;

endpackage

// File: rtl/wb_hold_reg.sv
// -----------------------------------------------------------------------------
// wb_hold_reg
// One-entry holding register for a single write-back producer.
// Ports:
//   clk, rst_n    : clock, synchronous active-low reset
//   src_vld       : producer result valid
//   src_rdy       : entry can accept this cycle (empty, or being granted now)
//   src_addr/data : producer destination register and result
//   grant         : arbiter retires the held entry this cycle
//   bypass        : accepted result goes straight to the output regs instead
//   held          : entry valid
//   held_addr/data: held destination register and result
//   held_old      : entry has survived at least one edge without retiring;
//                   used as the age stamp when both producers are holding
// Results addressed to register 0 are accepted but never captured.
// -----------------------------------------------------------------------------
import rf_wb_pkg::*;

module wb_hold_reg #(
    parameter int unsigned DATA_W = WB_DATA_W,
    parameter int unsigned ADDR_W = WB_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              src_vld,
    output logic              src_rdy,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [DATA_W-1:0] src_data,
    input  logic              grant,
    input  logic              bypass,
    output logic              held,
    output logic [ADDR_W-1:0] held_addr,
    output logic [DATA_W-1:0] held_data,
    output logic              held_old
);

    logic capture;

    // Ready depends only on registered state and the grant, never on src_vld.
    assign src_rdy = ~held | grant;
    assign capture = src_vld & src_rdy & (src_addr != '0) & ~bypass;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            held      <= 1'b0;
            held_old  <= 1'b0;
            held_addr <= '0;
            held_data <= '0;
        end else if (capture) begin
            held      <= 1'b1;
            held_old  <= 1'b0;
            held_addr <= src_addr;
            held_data <= src_data;
        end else begin
            held      <= held & ~grant;
            held_old  <= held & ~grant;
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// -----------------------------------------------------------------------------
// rf_wb_arbiter
// Merges ALU and MEM results onto the register file's single write port.
// Each producer owns a one-entry holding register; an age-ordered arbiter
// retires one held write per cycle into registered we/dst_addr/dst.
// Ports:
//   clk, rst_n              : clock, synchronous active-low reset
//   alu_vld/rdy/addr/data   : ALU result handshake
//   mem_vld/rdy/addr/data   : MEM (load) result handshake
//   we, dst_addr, dst       : registered RF write port
//   pend_mask               : bit i set while a write to reg i is held or on
//                             the write port (decode uses it to stall reads)
// Build option:
//   WB_BYPASS_EN : with nothing held/granted, an accepted nonzero result is
//                  loaded straight into the output regs (one cycle sooner).
//                  MEM wins when both producers are eligible on the same edge.
// Register 0 is hardwired zero and is never written or marked pending.
// -----------------------------------------------------------------------------
import rf_wb_pkg::*;

module rf_wb_arbiter #(
    parameter int unsigned DATA_W = WB_DATA_W,
    parameter int unsigned ADDR_W = WB_ADDR_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 alu_vld,
    output logic                 alu_rdy,
    input  logic [ADDR_W-1:0]    alu_addr,
    input  logic [DATA_W-1:0]    alu_data,
    input  logic                 mem_vld,
    output logic                 mem_rdy,
    input  logic [ADDR_W-1:0]    mem_addr,
    input  logic [DATA_W-1:0]    mem_data,
    output logic                 we,
    output logic [ADDR_W-1:0]    dst_addr,
    output logic [DATA_W-1:0]    dst,
    output logic [2**ADDR_W-1:0] pend_mask
);

    logic              alu_held, mem_held;
    logic              alu_old, mem_old;
    logic [ADDR_W-1:0] alu_held_addr, mem_held_addr;
    logic [DATA_W-1:0] alu_held_data, mem_held_data;

    logic              grant_any, grant_alu, grant_mem;
    src_e              gsel;
    logic              alu_byp, mem_byp;

    logic              nxt_we;
    logic [ADDR_W-1:0] nxt_addr;
    logic [DATA_W-1:0] nxt_data;

    wb_hold_reg #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_alu_hold (
        .clk       (clk),
        .rst_n     (rst_n),
        .src_vld   (alu_vld),
        .src_rdy   (alu_rdy),
        .src_addr  (alu_addr),
        .src_data  (alu_data),
        .grant     (grant_alu),
        .bypass    (alu_byp),
        .held      (alu_held),
        .held_addr (alu_held_addr),
        .held_data (alu_held_data),
        .held_old  (alu_old)
    );

    wb_hold_reg #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mem_hold (
        .clk       (clk),
        .rst_n     (rst_n),
        .src_vld   (mem_vld),
        .src_rdy   (mem_rdy),
        .src_addr  (mem_addr),
        .src_data  (mem_data),
        .grant     (grant_mem),
        .bypass    (mem_byp),
        .held      (mem_held),
        .held_addr (mem_held_addr),
        .held_data (mem_held_data),
        .held_old  (mem_old)
    );

    // Age arbiter. A grant is issued every cycle any entry is held, so at most
    // one entry can be "old"; when both are fresh (captured on the same edge)
    // MEM belongs to the older instruction and goes first.
    always_comb begin
        grant_any = alu_held | mem_held;
        gsel      = SRC_MEM;
        if (alu_held && (!mem_held || (alu_old && !mem_old)))
            gsel = SRC_ALU;
    end

    assign grant_alu = grant_any & (gsel == SRC_ALU);
    assign grant_mem = grant_any & (gsel == SRC_MEM);

`ifdef WB_BYPASS_EN
    // Eligible only with the own entry empty and no held entry retiring now,
    // which keeps the output port strictly in acceptance order.
    assign mem_byp = mem_vld & ~mem_held & ~grant_any & (mem_addr != '0);
    assign alu_byp = alu_vld & ~alu_held & ~grant_any & (alu_addr != '0) & ~mem_byp;
`else
    assign mem_byp = 1'b0;
    assign alu_byp = 1'b0;
`endif

    // Next write-port contents; address/data hold their value when idle.
    always_comb begin
        nxt_we   = 1'b0;
        nxt_addr = dst_addr;
        nxt_data = dst;
        if (mem_byp) begin
            nxt_we   = 1'b1;
            nxt_addr = mem_addr;
            nxt_data = mem_data;
        end else if (alu_byp) begin
            nxt_we   = 1'b1;
            nxt_addr = alu_addr;
            nxt_data = alu_data;
        end else if (grant_any) begin
            nxt_we = 1'b1;
            unique case (gsel)
                SRC_ALU: begin
                    nxt_addr = alu_held_addr;
                    nxt_data = alu_held_data;
                end
                SRC_MEM: begin
                    nxt_addr = mem_held_addr;
                    nxt_data = mem_held_data;
                end
                default: begin
                    nxt_addr = dst_addr;
                    nxt_data = dst;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            we       <= 1'b0;
            dst_addr <= '0;
            dst      <= '0;
        end else begin
            we       <= nxt_we;
            dst_addr <= nxt_addr;
            dst      <= nxt_data;
        end
    end

    // Pending mask from registered state only.
    always_comb begin
        pend_mask = '0;
        if (alu_held)
            pend_mask[alu_held_addr] = 1'b1;
        if (mem_held)
            pend_mask[mem_held_addr] = 1'b1;
        if (we)
            pend_mask[dst_addr] = 1'b1;
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rf_wb_arbiter
// Directed bench for rf_wb_arbiter. Accepted nonzero writes are pushed to a
// scoreboard queue just before the edge that accepts them (MEM before ALU on
// the same edge); every cycle with we=1 pops and compares the oldest entry.
// Timing-specific checks follow the WB_BYPASS_EN build option.
// -----------------------------------------------------------------------------
import rf_wb_pkg::*;

module tb_rf_wb_arbiter;

    logic        clk;
    logic        rst_n;
    logic        alu_vld, mem_vld;
    logic        alu_rdy, mem_rdy;
    logic [3:0]  alu_addr, mem_addr;
    logic [15:0] alu_data, mem_data;
    logic        we;
    logic [3:0]  dst_addr;
    logic [15:0] dst;
    logic [15:0] pend_mask;

    int unsigned total;
    int unsigned bad;
    int unsigned wr_cnt;
    logic        acc_a, acc_m;
    wb_req_t     sb[$];

    rf_wb_arbiter #(
        .DATA_W (16),
        .ADDR_W (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .alu_vld   (alu_vld),
        .alu_rdy   (alu_rdy),
        .alu_addr  (alu_addr),
        .alu_data  (alu_data),
        .mem_vld   (mem_vld),
        .mem_rdy   (mem_rdy),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .we        (we),
        .dst_addr  (dst_addr),
        .dst       (dst),
        .pend_mask (pend_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One clock cycle: at the falling edge check any write on the port against
    // the scoreboard, then record what the next rising edge accepts.
    task automatic tick();
        wb_req_t e;
        @(negedge clk);
        if (we === 1'b1) begin
            wr_cnt++;
            total++;
            assert (sb.size() != 0) else begin
                bad++;
                $error("FAIL sb_unexpected_we observed=addr %0h data %0h expected=no write", dst_addr, dst);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("sb_addr", 32'(dst_addr), 32'(e.addr));
                chk("sb_data", 32'(dst), 32'(e.data));
            end
        end
        acc_a = 1'b0;
        acc_m = 1'b0;
        if (rst_n) begin
            acc_m = mem_vld & mem_rdy;
            acc_a = alu_vld & alu_rdy;
            if (acc_m && mem_addr != 4'd0) sb.push_back('{addr: mem_addr, data: mem_data});
            if (acc_a && alu_addr != 4'd0) sb.push_back('{addr: alu_addr, data: alu_data});
        end else begin
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int unsigned ai, mi, it;
        total    = 0;
        bad      = 0;
        wr_cnt   = 0;
        rst_n    = 1'b0;
        alu_vld  = 1'b1;
        alu_addr = 4'd9;
        alu_data = 16'h1234;
        mem_vld  = 1'b0;
        mem_addr = 4'd0;
        mem_data = 16'h0000;

        // 1: reset with ALU valid, first write only after release
        tick();
        tick();
        chk("rst_we", 32'(we), 32'd0);
        chk("rst_pend", 32'(pend_mask), 32'h0);
        chk("rst_dst_addr", 32'(dst_addr), 32'h0);
        chk("rst_dst", 32'(dst), 32'h0);
        rst_n = 1'b1;
        tick();
        alu_vld = 1'b0;
`ifdef WB_BYPASS_EN
        chk("rel_we", 32'(we), 32'd1);
        chk("rel_addr", 32'(dst_addr), 32'd9);
`else
        chk("rel_we", 32'(we), 32'd0);
        chk("rel_pend", 32'(pend_mask), 32'h0200);
        tick();
        chk("rel_we2", 32'(we), 32'd1);
        chk("rel_addr", 32'(dst_addr), 32'd9);
        chk("rel_data", 32'(dst), 32'h1234);
`endif
        tick();
        chk("rel_idle", 32'(we), 32'd0);

        // 2: single ALU write r3 = BEEF
        chk("alu_rdy_idle", 32'(alu_rdy), 32'd1);
        alu_vld = 1'b1; alu_addr = 4'd3; alu_data = 16'hBEEF;
        tick();
        alu_vld = 1'b0;
`ifndef WB_BYPASS_EN
        chk("single_pend_n1", 32'(pend_mask), 32'h0008);
        chk("single_we_n1", 32'(we), 32'd0);
        tick();
`endif
        chk("single_we", 32'(we), 32'd1);
        chk("single_addr", 32'(dst_addr), 32'd3);
        chk("single_data", 32'(dst), 32'hBEEF);
        chk("single_pend_wr", 32'(pend_mask), 32'h0008);
        tick();
        chk("single_done_we", 32'(we), 32'd0);
        chk("single_done_pend", 32'(pend_mask), 32'h0);
        chk("single_hold_addr", 32'(dst_addr), 32'd3);

        // 3: same-edge collision on r5, MEM first
        alu_vld = 1'b1; alu_addr = 4'd5; alu_data = 16'h1111;
        mem_vld = 1'b1; mem_addr = 4'd5; mem_data = 16'h2222;
        tick();
        alu_vld = 1'b0; mem_vld = 1'b0;
`ifndef WB_BYPASS_EN
        chk("coll_pend", 32'(pend_mask), 32'h0020);
        chk("coll_mem_rdy", 32'(mem_rdy), 32'd1);
        chk("coll_alu_rdy", 32'(alu_rdy), 32'd0);
        tick();
`endif
        chk("coll_we1", 32'(we), 32'd1);
        chk("coll_data1", 32'(dst), 32'h2222);
        tick();
        chk("coll_we2", 32'(we), 32'd1);
        chk("coll_addr2", 32'(dst_addr), 32'd5);
        chk("coll_data2", 32'(dst), 32'h1111);
        tick();
        chk("coll_idle", 32'(we), 32'd0);

        // 4: MEM write to r0 is accepted and dropped
        chk("r0_mem_rdy", 32'(mem_rdy), 32'd1);
        mem_vld = 1'b1; mem_addr = 4'd0; mem_data = 16'hFFFF;
        tick();
        mem_vld = 1'b0;
        chk("r0_pend", 32'(pend_mask), 32'h0);
        chk("r0_we", 32'(we), 32'd0);
        tick();
        chk("r0_we2", 32'(we), 32'd0);
        chk("r0_pend2", 32'(pend_mask), 32'h0);

        // 6: ALU alone r7 = 00A5 from idle, then MEM r2 + ALU r7 together
        alu_vld = 1'b1; alu_addr = 4'd7; alu_data = 16'h00A5;
        tick();
        alu_vld = 1'b0;
`ifndef WB_BYPASS_EN
        chk("byp_pend_n1", 32'(pend_mask), 32'h0080);
        tick();
`endif
        chk("byp_we", 32'(we), 32'd1);
        chk("byp_addr", 32'(dst_addr), 32'd7);
        chk("byp_data", 32'(dst), 32'h00A5);
        tick();
        alu_vld = 1'b1; alu_addr = 4'd7; alu_data = 16'h00A6;
        mem_vld = 1'b1; mem_addr = 4'd2; mem_data = 16'h0BBB;
        tick();
        alu_vld = 1'b0; mem_vld = 1'b0;
`ifdef WB_BYPASS_EN
        chk("byp2_pend", 32'(pend_mask), 32'h0084);
`else
        chk("byp2_pend", 32'(pend_mask), 32'h0084);
        tick();
`endif
        chk("byp2_we1", 32'(we), 32'd1);
        chk("byp2_addr1", 32'(dst_addr), 32'd2);
        tick();
        chk("byp2_addr2", 32'(dst_addr), 32'd7);
        chk("byp2_data2", 32'(dst), 32'h00A6);
        tick();

        // reset mid-operation discards held results
        alu_vld = 1'b1; alu_addr = 4'd4; alu_data = 16'h4444;
        mem_vld = 1'b1; mem_addr = 4'd6; mem_data = 16'h6666;
        tick();
        alu_vld = 1'b0; mem_vld = 1'b0;
        rst_n = 1'b0;
        tick();
        chk("midrst_we", 32'(we), 32'd0);
        chk("midrst_pend", 32'(pend_mask), 32'h0);
        rst_n = 1'b1;
        tick();
        chk("midrst_we2", 32'(we), 32'd0);
        chk("midrst_pend2", 32'(pend_mask), 32'h0);

        // 5: streaming, 8 results per source
        wr_cnt = 0;
        ai = 0; mi = 0; it = 0;
        while ((ai < 8 || mi < 8) && it < 64) begin
            alu_vld  = (ai < 8);
            alu_addr = 4'(ai + 1);
            alu_data = 16'hA000 + 16'(ai);
            mem_vld  = (mi < 8);
            mem_addr = 4'(15 - mi);
            mem_data = 16'hB000 + 16'(mi);
            if (it >= 2 && ai < 8 && mi < 8)
                chk("stream_rdy_alt", 32'(alu_rdy ^ mem_rdy), 32'd1);
            tick();
            if (acc_a) ai++;
            if (acc_m) mi++;
            it++;
        end
        alu_vld = 1'b0; mem_vld = 1'b0;
        chk("stream_all_accepted", 32'((ai == 8) && (mi == 8)), 32'd1);
        for (int k = 0; k < 6; k++) tick();
        chk("stream_writes", 32'(wr_cnt), 32'd16);
        chk("stream_sb_empty", 32'(sb.size()), 32'd0);
        chk("stream_pend_clear", 32'(pend_mask), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
